// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single memory port: CPU priority with a DMA
// anti-starvation streak limit, one transfer at a time, plus a ready watchdog.
module mem_bus_arbiter #(
  parameter int unsigned FAIR_LIMIT = 4,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        mem_req,
  output logic        mem_w,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_owner,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned WW = 16;

  typedef enum logic [1:0] {IDLE, CPU_XFER, DMA_XFER} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [WW-1:0] wd_cnt;

  logic          grant_dma_c;
  logic          grant_cpu_c;
  logic          wd_expire_c;
  logic          xfer_done_c;
  logic [DW-1:0] xfer_rdata_c;

  // A port acked this cycle is masked so its stale req cannot re-grant; the
  // raw cpu_req still holds DMA off until the streak limit is reached.
  always_comb begin
    grant_dma_c  = dma_req && !dma_ack && (!cpu_req || (streak == SW'(FAIR_LIMIT)));
    grant_cpu_c  = cpu_req && !cpu_ack && !grant_dma_c;
    wd_expire_c  = ((32'(wd_cnt) + 32'd1) == TIMEOUT);
    xfer_done_c  = mem_ready || wd_expire_c;
    xfer_rdata_c = '0;
    if (!mem_w) xfer_rdata_c = mem_ready ? mem_rdata : ERR_DATA;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      streak      <= '0;
      wd_cnt      <= '0;
      cpu_rdata   <= '0;
      cpu_ack     <= 1'b0;
      dma_rdata   <= '0;
      dma_ack     <= 1'b0;
      mem_req     <= 1'b0;
      mem_w       <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      bus_owner   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (grant_dma_c) begin
            state     <= DMA_XFER;
            mem_req   <= 1'b1;
            mem_w     <= dma_we;
            mem_addr  <= dma_addr;
            mem_wdata <= dma_wdata;
            bus_owner <= 1'b1;
            streak    <= '0;
          end else if (grant_cpu_c) begin
            state     <= CPU_XFER;
            mem_req   <= 1'b1;
            mem_w     <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            bus_owner <= 1'b0;
            if (!dma_req) streak <= '0;
            else if (streak != SW'(FAIR_LIMIT)) streak <= streak + 1'b1;
          end else if (!dma_req) begin
            streak <= '0;
          end
        end

        CPU_XFER, DMA_XFER: begin
          if (xfer_done_c) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            wd_cnt  <= '0;
            if (state == CPU_XFER) begin
              cpu_ack   <= 1'b1;
              cpu_rdata <= xfer_rdata_c;
            end else begin
              dma_ack   <= 1'b1;
              dma_rdata <= xfer_rdata_c;
            end
            // Timeout set takes precedence over a simultaneous err_clr.
            if (!mem_ready) timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (FAIR_LIMIT=4, TIMEOUT=8).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic        mem_req, mem_w;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        bus_owner, timeout_err;
  logic        err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.FAIR_LIMIT(4), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_req(mem_req), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_owner(bus_owner), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if ({cpu_ack, dma_ack, mem_req, mem_w, bus_owner, timeout_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000",
                         {cpu_ack, dma_ack, mem_req, mem_w, bus_owner, timeout_err});
    end
    n_checks++;
    if ((mem_addr | mem_wdata | cpu_rdata | dma_rdata) !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 00000000",
                         mem_addr | mem_wdata | cpu_rdata | dma_rdata);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle_req: got %b expected 0", mem_req); end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    mem_rdata = 32'h12345678; mem_ready = 1'b1;
    tick();
    n_checks++;
    if ({mem_req, mem_w, bus_owner, cpu_ack} !== 4'b1000) begin
      n_fail++; $display("FAIL cpu_rd_grant: got %b expected 1000", {mem_req, mem_w, bus_owner, cpu_ack});
    end
    n_checks++;
    if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL cpu_rd_addr: got %h expected 00000100", mem_addr); end
    tick();
    n_checks++;
    if ({mem_req, cpu_ack} !== 2'b01) begin
      n_fail++; $display("FAIL cpu_rd_ack: got %b expected 01", {mem_req, cpu_ack});
    end
    n_checks++;
    if (cpu_rdata !== 32'h12345678) begin n_fail++; $display("FAIL cpu_rd_data: got %h expected 12345678", cpu_rdata); end
    cpu_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    tick();
    n_checks++;
    if ({mem_req, cpu_ack} !== 2'b00 || cpu_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL cpu_rd_after: got req/ack %b rdata %h expected 00 12345678", {mem_req, cpu_ack}, cpu_rdata);
    end
  endtask

  task automatic test_dma_write_wait();
    int bad = 0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'hCAFEF00D;
    mem_ready = 1'b0; mem_rdata = 32'h77777777;
    tick();
    for (int i = 0; i < 4; i++) begin
      if ({mem_req, mem_w, bus_owner, dma_ack} !== 4'b1110 ||
          mem_addr !== 32'h20 || mem_wdata !== 32'hCAFEF00D) bad++;
      dma_addr = 32'hFFFF0000; dma_wdata = 32'h0;
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL dma_wr_stable: got %0d bad cycles expected 0", bad); end
    n_checks++;
    if ({dma_ack, mem_req, bus_owner} !== 3'b101) begin
      n_fail++; $display("FAIL dma_wr_ack: got %b expected 101", {dma_ack, mem_req, bus_owner});
    end
    n_checks++;
    if (dma_rdata !== 32'h0) begin n_fail++; $display("FAIL dma_wr_rdata: got %h expected 00000000", dma_rdata); end
    dma_req = 1'b0; dma_we = 1'b0; mem_ready = 1'b0;
    tick();
    n_checks++;
    if ({dma_ack, bus_owner} !== 2'b01) begin
      n_fail++; $display("FAIL dma_wr_single_ack: got %b expected 01", {dma_ack, bus_owner});
    end
  endtask

  task automatic test_fairness();
    logic [9:0] owners = '0;
    int g = 0, cacks = 0, dacks = 0, dbl = 0;
    logic pc = 1'b0, pd = 1'b0, prev_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h600;
    mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
    for (int cyc = 0; cyc < 100 && g < 10; cyc++) begin
      tick();
      if (cpu_ack) cacks++;
      if (dma_ack) dacks++;
      if ((cpu_ack && pc) || (dma_ack && pd)) dbl++;
      pc = cpu_ack; pd = dma_ack;
      if (mem_req && !prev_req) begin owners[g] = bus_owner; g++; end
      prev_req = mem_req;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (cpu_ack) cacks++;
      if (dma_ack) dacks++;
      if ((cpu_ack && pc) || (dma_ack && pd)) dbl++;
      pc = cpu_ack; pd = dma_ack;
    end
    mem_ready = 1'b0;
    n_checks++;
    if (g !== 10) begin n_fail++; $display("FAIL fair_grant_count: got %0d expected 10", g); end
    n_checks++;
    if (owners !== 10'b1000010000) begin
      n_fail++; $display("FAIL fair_sequence: got %b expected 1000010000 (bit0 first, 1=DMA)", owners);
    end
    n_checks++;
    if (cacks !== 8 || dacks !== 2) begin
      n_fail++; $display("FAIL fair_ack_counts: got cpu %0d dma %0d expected cpu 8 dma 2", cacks, dacks);
    end
    n_checks++;
    if (dbl !== 0) begin n_fail++; $display("FAIL fair_double_ack: got %0d expected 0", dbl); end
  endtask

  task automatic test_timeout();
    int bad = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200; mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (mem_req !== 1'b1 || cpu_ack !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL to_wait: got %0d bad cycles expected 0", bad); end
    n_checks++;
    if ({cpu_ack, mem_req, timeout_err} !== 3'b101) begin
      n_fail++; $display("FAIL to_abort: got %b expected 101", {cpu_ack, mem_req, timeout_err});
    end
    n_checks++;
    if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL to_rdata: got %h expected deadbeef", cpu_rdata); end
    cpu_req = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b expected 0", timeout_err); end
  endtask

  task automatic test_timeout_boundary();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
    mem_ready = 1'b0; mem_rdata = 32'h0BADCAFE;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) mem_ready = 1'b1;
      tick();
    end
    n_checks++;
    if ({cpu_ack, timeout_err} !== 2'b10 || cpu_rdata !== 32'h0BADCAFE) begin
      n_fail++; $display("FAIL to_boundary: got ack/err %b rdata %h expected 10 0badcafe",
                         {cpu_ack, timeout_err}, cpu_rdata);
    end
    cpu_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_err_set_wins();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h310; mem_ready = 1'b0;
    err_clr = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if ({cpu_ack, timeout_err} !== 2'b11) begin
      n_fail++; $display("FAIL err_set_wins: got %b expected 11", {cpu_ack, timeout_err});
    end
    cpu_req = 1'b0;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL err_clr_after: got %b expected 0", timeout_err); end
  endtask

  task automatic test_reset_mid_xfer();
    int acks = 0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40; mem_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if ({mem_req, bus_owner} !== 2'b11) begin
      n_fail++; $display("FAIL rst_pre: got %b expected 11", {mem_req, bus_owner});
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({cpu_ack, dma_ack, mem_req, mem_w, bus_owner, timeout_err} !== 6'b0 ||
        (mem_addr | mem_wdata | cpu_rdata | dma_rdata) !== 32'h0) begin
      n_fail++; $display("FAIL rst_async: got flags %b data-or %h expected 000000 00000000",
                         {cpu_ack, dma_ack, mem_req, mem_w, bus_owner, timeout_err},
                         mem_addr | mem_wdata | cpu_rdata | dma_rdata);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      if (dma_ack) acks++;
    end
    dma_addr = 32'h44; mem_rdata = 32'h55AA55AA; mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    if (dma_ack) acks++;
    n_checks++;
    if ({mem_req, bus_owner} !== 2'b11 || mem_addr !== 32'h44) begin
      n_fail++; $display("FAIL rst_regrant: got req/owner %b addr %h expected 11 00000044", {mem_req, bus_owner}, mem_addr);
    end
    tick();
    n_checks++;
    if (acks !== 0 || dma_ack !== 1'b1 || dma_rdata !== 32'h55AA55AA) begin
      n_fail++; $display("FAIL rst_fresh_xfer: got early acks %0d ack %b rdata %h expected 0 1 55aa55aa",
                         acks, dma_ack, dma_rdata);
    end
    dma_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_hold_req();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h400;
    mem_ready = 1'b1; mem_rdata = 32'h11112222;
    tick();
    tick();
    n_checks++;
    if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL hold_first_ack: got %b expected 1", cpu_ack); end
    tick();
    n_checks++;
    if ({mem_req, cpu_ack} !== 2'b00) begin
      n_fail++; $display("FAIL hold_no_regrant: got %b expected 00", {mem_req, cpu_ack});
    end
    mem_rdata = 32'h33334444;
    tick();
    n_checks++;
    if ({mem_req, bus_owner} !== 2'b10 || mem_addr !== 32'h400) begin
      n_fail++; $display("FAIL hold_second_grant: got %b addr %h expected 10 00000400", {mem_req, bus_owner}, mem_addr);
    end
    mem_ready = 1'b0; cpu_req = 1'b0; cpu_addr = 32'h999;
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h400 || cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL hold_latched: got req %b addr %h ack %b expected 1 00000400 0", mem_req, mem_addr, cpu_ack);
    end
    mem_ready = 1'b1;
    tick();
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h33334444) begin
      n_fail++; $display("FAIL hold_drop_ack: got ack %b rdata %h expected 1 33334444", cpu_ack, cpu_rdata);
    end
    mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write_wait();
    test_fairness();
    test_timeout();
    test_timeout_boundary();
    test_err_set_wins();
    test_reset_mid_xfer();
    test_hold_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
